// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the CNN 3x3 convolution sequencer.
// CNN_SEQ_RELU_EN selects ReLU+saturation post-processing instead of plain truncation.
package cnn_seq_pkg;

  localparam int TAPS = 9;
  localparam int KDIM = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CLEAR = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    WRITE = 3'd5,
    NEXT  = 3'd6,
    FIN   = 3'd7
  } state_t;

  // Maps a signed accumulator onto an unsigned dw-bit output word (returned zero-extended).
  function automatic logic [31:0] post_px(input logic signed [31:0] acc, input int unsigned dw);
    logic [31:0] max_val;
    max_val = (32'd1 << dw) - 32'd1;
`ifdef CNN_SEQ_RELU_EN
    if (acc < 0) return 32'd0;
    if ($unsigned(acc) > max_val) return max_val;
    return $unsigned(acc);
`else
    return $unsigned(acc) & max_val;
`endif
  endfunction

endpackage

// File: rtl/cnn_window_addr_gen.sv
// Window/tap counters for the convolution walk; produces pixel read and result write addresses.
module cnn_window_addr_gen
  import cnn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  win_init_i,
  input  logic                  tap_clr_i,
  input  logic                  tap_step_i,
  input  logic                  win_step_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [DIM_WIDTH-1:0]  img_w_i,
  input  logic [DIM_WIDTH-1:0]  img_h_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [3:0]            tap_o,
  output logic                  tap_last_o,
  output logic                  win_last_o
);

  logic [DIM_WIDTH-1:0] row_q, col_q;
  logic [1:0]           ky_q, kx_q;
  logic [3:0]           tap_q;
  logic [DIM_WIDTH-1:0] w_m2, w_m3, h_m3;
  logic [DIM_WIDTH:0]   rd_row, rd_col;

  assign w_m2 = img_w_i - DIM_WIDTH'(2);
  assign w_m3 = img_w_i - DIM_WIDTH'(3);
  assign h_m3 = img_h_i - DIM_WIDTH'(3);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      ky_q  <= '0;
      kx_q  <= '0;
      tap_q <= '0;
    end else begin
      if (win_init_i) begin
        row_q <= '0;
        col_q <= '0;
      end else if (win_step_i) begin
        if (col_q == w_m3) begin
          col_q <= '0;
          row_q <= row_q + DIM_WIDTH'(1);
        end else begin
          col_q <= col_q + DIM_WIDTH'(1);
        end
      end
      // ky/kx track tap/3 and tap%3 so no divider is needed.
      if (tap_clr_i) begin
        tap_q <= '0;
        ky_q  <= '0;
        kx_q  <= '0;
      end else if (tap_step_i) begin
        tap_q <= tap_q + 4'd1;
        if (kx_q == 2'(KDIM - 1)) begin
          kx_q <= '0;
          ky_q <= ky_q + 2'd1;
        end else begin
          kx_q <= kx_q + 2'd1;
        end
      end
    end
  end

  assign rd_row = (DIM_WIDTH+1)'(row_q) + (DIM_WIDTH+1)'(ky_q);
  assign rd_col = (DIM_WIDTH+1)'(col_q) + (DIM_WIDTH+1)'(kx_q);

  assign rd_addr_o = in_base_i + ADDR_WIDTH'(rd_row) * ADDR_WIDTH'(img_w_i) + ADDR_WIDTH'(rd_col);
  assign wr_addr_o = out_base_i + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(w_m2) + ADDR_WIDTH'(col_q);

  assign tap_o      = tap_q;
  assign tap_last_o = (tap_q == 4'(TAPS - 1));
  assign win_last_o = (col_q == w_m3) && (row_q == h_m3);

endmodule

// File: rtl/cnn_conv_sequencer.sv
// Sequencer FSM walking every valid 3x3 window, feeding the MAC and writing post-processed results.
// Post-processing is selected by CNN_SEQ_RELU_EN (see cnn_seq_pkg::post_px).
module cnn_conv_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [DIM_WIDTH-1:0]  img_w_i,
  input  logic [DIM_WIDTH-1:0]  img_h_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mac_clr_o,
  output logic                  mac_valid_o,
  output logic [DATA_WIDTH-1:0] mac_pix_o,
  output logic [3:0]            mac_tap_o,
  input  logic [ACC_WIDTH-1:0]  mac_acc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            dbg_state_o
);

  // Handshake: start_i is a single-cycle request honoured only in IDLE; mem_rd_en_o returns
  // data one cycle later, which is forwarded to the MAC with mac_valid_o in that same cycle.

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] in_base_q, out_base_q;
  logic [DIM_WIDTH-1:0]  img_w_q, img_h_q;
  logic                  err_q, mac_valid_q;
  logic [3:0]            mac_tap_q;
  logic                  start_acc, dims_bad;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [3:0]            tap;
  logic                  tap_last, win_last;
  logic signed [31:0]    acc_ext;

  assign start_acc = (state_q == IDLE) && start_i;
  assign dims_bad  = (img_w_q < DIM_WIDTH'(KDIM)) || (img_h_q < DIM_WIDTH'(KDIM));
  assign acc_ext   = {{(32-ACC_WIDTH){mac_acc_i[ACC_WIDTH-1]}}, mac_acc_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = CHECK;
      CHECK: state_d = dims_bad ? FIN : CLEAR;
      CLEAR: state_d = READ;
      READ:  if (tap_last) state_d = DRAIN;
      DRAIN: state_d = WRITE;
      WRITE: state_d = NEXT;
      NEXT:  state_d = win_last ? FIN : CLEAR;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_clr_o   = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      CLEAR: mac_clr_o = 1'b1;
      READ: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = rd_addr;
      end
      WRITE: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = wr_addr;
        mem_wdata_o = DATA_WIDTH'(post_px(acc_ext, DATA_WIDTH));
      end
      FIN: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_base_q   <= '0;
      out_base_q  <= '0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      err_q       <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_tap_q   <= '0;
    end else begin
      if (start_acc) begin
        in_base_q  <= in_base_i;
        out_base_q <= out_base_i;
        img_w_q    <= img_w_i;
        img_h_q    <= img_h_i;
        err_q      <= 1'b0;
      end else if (state_q == CHECK && dims_bad) begin
        err_q <= 1'b1;
      end
      mac_valid_q <= mem_rd_en_o;
      mac_tap_q   <= mem_rd_en_o ? tap : 4'd0;
    end
  end

  assign mac_valid_o = mac_valid_q;
  assign mac_tap_o   = mac_tap_q;
  assign mac_pix_o   = mem_rdata_i;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  cnn_window_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_WIDTH (DIM_WIDTH)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .win_init_i (state_q == CHECK),
    .tap_clr_i  (state_q == CLEAR),
    .tap_step_i ((state_q == READ) && !tap_last),
    .win_step_i (state_q == NEXT),
    .in_base_i  (in_base_q),
    .out_base_i (out_base_q),
    .img_w_i    (img_w_q),
    .img_h_i    (img_h_q),
    .rd_addr_o  (rd_addr),
    .wr_addr_o  (wr_addr),
    .tap_o      (tap),
    .tap_last_o (tap_last),
    .win_last_o (win_last)
  );

endmodule
